// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART TX path among N_REQ requesters.
// Round-robin arbitration, packet-locked: an owner keeps the UART until its
// byte flagged req_last is accepted.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   req_valid    per-requester byte valid            [N_REQ]
//   req_data     per-requester byte, slice i*DATA_W  [N_REQ*DATA_W]
//   req_last     per-requester end-of-packet flag    [N_REQ]
//   req_ready    per-requester accept                [N_REQ]
//   tx_valid     byte valid to the UART
//   tx_data      byte to the UART                    [DATA_W]
//   tx_ready     UART accepts the byte
//   grant        one-hot owner, zero when idle       [N_REQ]
//   busy         a packet is owned
//   timeout_evt  one-cycle pulse on a forced release
//
// Optional: define UART_ARB_TIMEOUT_EN to release a grant whose owner has
// kept req_valid low for TIMEOUT locked cycles.

module uart_tx_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_valid,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    timeout_evt
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_grant_nxt;
    logic [IW-1:0]    r_gidx;
    logic [IW-1:0]    w_gidx_nxt;
    logic [IW-1:0]    r_last_idx;
    logic [IW-1:0]    w_last_nxt;
    logic             w_found;
    logic [IW-1:0]    w_pick;
    logic             w_own_valid;
    logic             w_own_last;
    logic             w_lock;
    logic             w_xfer;
    logic             w_force;

    // Scan starts one past the previous owner so every requester
    // eventually gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_last_idx) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(r_last_idx) + k) % N_REQ);
            end
        end
    end

    assign w_lock      = (r_state == LOCK);
    assign w_own_valid = req_valid[r_gidx];
    assign w_own_last  = req_last[r_gidx];

    // Zero-latency pass-through of the owner's channel.
    assign tx_valid  = w_lock & w_own_valid;
    assign tx_data   = w_lock ? req_data[int'(r_gidx)*DATA_W +: DATA_W]
                              : '0;
    assign req_ready = (w_lock && tx_ready) ? r_grant : '0;
    assign w_xfer    = tx_valid & tx_ready;
    assign grant     = r_grant;
    assign busy      = w_lock;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last_idx;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt         = LOCK;
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_gidx_nxt          = w_pick;
                end
            end
            LOCK: begin
                if ((w_xfer && w_own_last) || w_force) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_gidx;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_last_idx <= IW'(N_REQ - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_gidx     <= w_gidx_nxt;
            r_last_idx <= w_last_nxt;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            r_to_evt;

    // Only owner silence counts; UART backpressure with data pending
    // is legitimate and never times out.
    assign w_force = w_lock && !w_own_valid
                     && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_to_evt <= 1'b0;
        end else begin
            r_to_evt <= w_force;
            if (!w_lock || w_xfer || w_force) begin
                r_to_cnt <= '0;
            end else if (!w_own_valid) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout_evt = r_to_evt;
`else
    assign w_force     = 1'b0;
    assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of uart_tx_arbiter
// with four requesters and TIMEOUT=10.

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam logic [N-1:0] ONE = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic [N-1:0]    grant;
    logic            busy;
    logic            timeout_evt;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_W(DW), .TO_W(16), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant(grant), .busy(busy), .timeout_evt(timeout_evt)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_data [N][$];
    bit         q_last [N][$];
    logic [7:0] exp_q  [N][$];
    bit         hold   [N];
    bit         txrdy;

    logic [N-1:0] prev_grant = '0;
    bit           prev_lastx = 1'b0;
    bit           prev_rst   = 1'b1;

    int         xfer_owner [$];
    logic [7:0] xfer_data  [$];
    logic [N-1:0] g_hist  [$];
    logic [N-1:0] rr_hist [$];
    logic         b_hist  [$];
    logic         v_hist  [$];
    logic         te_hist [$];

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input bit l);
        q_data[r].push_back(d);
        q_last[r].push_back(l);
        exp_q[r].push_back(d);
    endtask

    task automatic clear_q(input int r);
        q_data[r].delete();
        q_last[r].delete();
        exp_q[r].delete();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q_data[i].size() > 0) begin
                req_valid[i]          = !hold[i];
                req_data[i*DW +: DW]  = q_data[i][0];
                req_last[i]           = q_last[i][0];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = 8'h00;
                req_last[i]           = 1'b0;
            end
        end
        tx_ready = txrdy;
    endtask

    // One cycle: drive at negedge, observe, then wait for the next negedge.
    task automatic tick();
        int o;
        bit lx;
        drive();
        #1;
        g_hist.push_back(grant);
        rr_hist.push_back(req_ready);
        b_hist.push_back(busy);
        v_hist.push_back(tx_valid);
        te_hist.push_back(timeout_evt);
        lx = 1'b0;
        if (!rst) begin
            checks++;
            if ($isunknown(grant) || ((grant & (grant - ONE)) != '0)) begin
                failures++;
                $display("FAIL grant_onehot got=%b want=onehot0", grant);
            end
            checks++;
            if ($isunknown(req_ready) ||
                ((req_ready & (req_ready - ONE)) != '0) ||
                ((req_ready & ~grant) != '0)) begin
                failures++;
                $display("FAIL ready_onehot got=%b grant=%b", req_ready, grant);
            end
            checks++;
            if (busy !== (grant != '0)) begin
                failures++;
                $display("FAIL busy_vs_grant got=%b grant=%b", busy, grant);
            end
            checks++;
            if (busy === 1'b0 && tx_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_tx_valid got=%b want=0", tx_valid);
            end
            if (!prev_rst && prev_lastx) begin
                checks++;
                if (grant !== '0) begin
                    failures++;
                    $display("FAIL release_after_last got=%b want=0", grant);
                end
            end
            if (!prev_rst && prev_grant != '0 && grant != '0) begin
                checks++;
                if (grant !== prev_grant) begin
                    failures++;
                    $display("FAIL grant_switch got=%b want=%b",
                             grant, prev_grant);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                o = idx_of(grant);
                checks++;
                if (o < 0) begin
                    failures++;
                    $display("FAIL xfer_owner got=%b want=onehot", grant);
                end else if (exp_q[o].size() == 0) begin
                    failures++;
                    $display("FAIL xfer_extra req=%0d got=%h want=none",
                             o, tx_data);
                end else begin
                    if (tx_data !== exp_q[o][0] || req_ready[o] !== 1'b1) begin
                        failures++;
                        $display("FAIL xfer_data req=%0d got=%h want=%h rdy=%b",
                                 o, tx_data, exp_q[o][0], req_ready);
                    end
                    xfer_owner.push_back(o);
                    xfer_data.push_back(tx_data);
                    lx = req_last[o];
                    void'(exp_q[o].pop_front());
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i] && q_data[i].size() > 0) begin
                    void'(q_data[i].pop_front());
                    void'(q_last[i].pop_front());
                end
            end
        end
        prev_grant = grant;
        prev_lastx = lx;
        prev_rst   = rst;
        @(negedge clk);
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (q_data[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_until_empty(input int max);
        int n = 0;
        while (any_pending() && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (any_pending()) begin
            failures++;
            $display("FAIL drain_timeout got=pending want=empty after %0d", n);
        end
        repeat (2) tick();
    endtask

    task automatic wait_log(input int target, input int max);
        int n = 0;
        while (xfer_owner.size() < target && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (xfer_owner.size() < target) begin
            failures++;
            $display("FAIL wait_xfer got=%0d want=%0d",
                     xfer_owner.size(), target);
        end
    endtask

    task automatic test_reset();
        int b;
        rst   = 1'b1;
        txrdy = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        b = g_hist.size();
        tick();
        checks++;
        if (g_hist[b] !== '0 || b_hist[b] !== 1'b0 || v_hist[b] !== 1'b0 ||
            rr_hist[b] !== '0 || te_hist[b] !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals got=g%b b%b v%b r%b t%b want=all0",
                     g_hist[b], b_hist[b], v_hist[b], rr_hist[b], te_hist[b]);
        end
    endtask

    task automatic test_rr_basic();
        int b, lb;
        int         eo [5] = '{0, 0, 0, 1, 1};
        logic [7:0] ed [5] = '{8'h41, 8'h42, 8'h43, 8'h51, 8'h52};
        b  = g_hist.size();
        lb = xfer_owner.size();
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
        push(1, 8'h51, 0); push(1, 8'h52, 1);
        txrdy = 1'b1;
        repeat (8) tick();
        checks++;
        if (g_hist[b] !== 4'b0000 || v_hist[b] !== 1'b0) begin
            failures++;
            $display("FAIL arb_latency got=%b want=0000", g_hist[b]);
        end
        checks++;
        if (g_hist[b+1] !== 4'b0001 || g_hist[b+3] !== 4'b0001) begin
            failures++;
            $display("FAIL rr_first got=%b/%b want=0001",
                     g_hist[b+1], g_hist[b+3]);
        end
        checks++;
        if (g_hist[b+4] !== 4'b0000) begin
            failures++;
            $display("FAIL idle_gap got=%b want=0000", g_hist[b+4]);
        end
        checks++;
        if (g_hist[b+5] !== 4'b0010) begin
            failures++;
            $display("FAIL rr_second got=%b want=0010", g_hist[b+5]);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (xfer_owner.size() <= lb + k) begin
                failures++;
                $display("FAIL basic_log idx=%0d got=missing want=%h", k, ed[k]);
            end else if (xfer_owner[lb+k] != eo[k] || xfer_data[lb+k] !== ed[k]) begin
                failures++;
                $display("FAIL basic_log idx=%0d got=%0d:%h want=%0d:%h", k,
                         xfer_owner[lb+k], xfer_data[lb+k], eo[k], ed[k]);
            end
        end
    endtask

    task automatic test_alternate();
        int lb;
        int         eo [6] = '{0, 0, 1, 0, 1, 1};
        logic [7:0] ed [6] = '{8'h60, 8'h61, 8'h70, 8'h62, 8'h71, 8'h72};
        lb = xfer_owner.size();
        push(0, 8'h60, 0); push(0, 8'h61, 1); push(0, 8'h62, 1);
        push(1, 8'h70, 1); push(1, 8'h71, 0); push(1, 8'h72, 1);
        txrdy = 1'b1;
        run_until_empty(60);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (xfer_owner.size() <= lb + k) begin
                failures++;
                $display("FAIL alt_log idx=%0d got=missing want=%h", k, ed[k]);
            end else if (xfer_owner[lb+k] != eo[k] || xfer_data[lb+k] !== ed[k]) begin
                failures++;
                $display("FAIL alt_log idx=%0d got=%0d:%h want=%0d:%h", k,
                         xfer_owner[lb+k], xfer_data[lb+k], eo[k], ed[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lb;
        int         eo [5] = '{0, 0, 0, 0, 1};
        logic [7:0] ed [5] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h90};
        lb = xfer_owner.size();
        push(0, 8'h80, 0); push(0, 8'h81, 0); push(0, 8'h82, 0);
        push(0, 8'h83, 1); push(1, 8'h90, 1);
        txrdy = 1'b1;
        wait_log(lb + 2, 10);
        txrdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0001 || req_ready !== 4'b0000 ||
                tx_valid !== 1'b1 || tx_data !== 8'h82) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=g%b r%b v%b d%h want=g0001 r0000 v1 d82",
                         c, grant, req_ready, tx_valid, tx_data);
            end
        end
        txrdy = 1'b1;
        run_until_empty(30);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (xfer_owner.size() <= lb + k) begin
                failures++;
                $display("FAIL bp_log idx=%0d got=missing want=%h", k, ed[k]);
            end else if (xfer_owner[lb+k] != eo[k] || xfer_data[lb+k] !== ed[k]) begin
                failures++;
                $display("FAIL bp_log idx=%0d got=%0d:%h want=%0d:%h", k,
                         xfer_owner[lb+k], xfer_data[lb+k], eo[k], ed[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b, lb;
        txrdy = 1'b1;
        push(0, 8'hA9, 1);
        run_until_empty(10);
        lb = xfer_owner.size();
        push(1, 8'hA0, 0); push(1, 8'hA1, 0);
        push(1, 8'hA2, 0); push(1, 8'hA3, 1);
        wait_log(lb + 1, 10);
        rst   = 1'b1;
        txrdy = 1'b0;
        tick();
        rst   = 1'b0;
        txrdy = 1'b1;
        clear_q(1);
        push(0, 8'hB0, 1);
        push(1, 8'hB1, 1);
        b  = g_hist.size();
        lb = xfer_owner.size();
        run_until_empty(20);
        checks++;
        if (g_hist[b] !== '0 || b_hist[b] !== 1'b0 || v_hist[b] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_state got=g%b b%b v%b want=0 0 0",
                     g_hist[b], b_hist[b], v_hist[b]);
        end
        checks++;
        if (g_hist[b+1] !== 4'b0001) begin
            failures++;
            $display("FAIL rst_ptr got=%b want=0001", g_hist[b+1]);
        end
        checks++;
        if (xfer_owner.size() < lb + 2 ||
            xfer_data[lb] !== 8'hB0 || xfer_data[lb+1] !== 8'hB1) begin
            failures++;
            $display("FAIL rst_order got=%0d bytes want=B0,B1",
                     xfer_owner.size() - lb);
        end
    endtask

    task automatic test_timeout();
        int b, lb;
        bit te_seen;
        txrdy = 1'b1;
        // 9-cycle owner stall never forces a release
        lb = xfer_owner.size();
        push(0, 8'hE0, 0); push(0, 8'hE1, 1);
        wait_log(lb + 1, 10);
        hold[0] = 1'b1;
        push(1, 8'hF0, 1);
        b = g_hist.size();
        repeat (9) tick();
        hold[0] = 1'b0;
        tick();
        te_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (te_hist[b+k] !== 1'b0 || g_hist[b+k] !== 4'b0001) te_seen = 1'b1;
        end
        checks++;
        if (te_seen) begin
            failures++;
            $display("FAIL stall9_hold got=release want=held");
        end
        run_until_empty(20);
        checks++;
        if (xfer_data.size() < lb + 3 || xfer_data[lb+1] !== 8'hE1 ||
            xfer_data[lb+2] !== 8'hF0) begin
            failures++;
            $display("FAIL stall9_order got=%0d bytes want=E0,E1,F0",
                     xfer_data.size() - lb);
        end
        // 10-cycle owner stall
        lb = xfer_owner.size();
        push(0, 8'hC0, 0); push(0, 8'hC1, 1);
        wait_log(lb + 1, 10);
        hold[0] = 1'b1;
        push(1, 8'hD0, 1);
        b = g_hist.size();
        repeat (12) tick();
`ifdef UART_ARB_TIMEOUT_EN
        te_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (te_hist[b+k] !== 1'b0 || g_hist[b+k] !== 4'b0001) te_seen = 1'b1;
        end
        checks++;
        if (te_seen) begin
            failures++;
            $display("FAIL to_early got=release want=held 10 cycles");
        end
        checks++;
        if (te_hist[b+10] !== 1'b1 || g_hist[b+10] !== 4'b0000) begin
            failures++;
            $display("FAIL to_pulse got=t%b g%b want=t1 g0000",
                     te_hist[b+10], g_hist[b+10]);
        end
        checks++;
        if (te_hist[b+11] !== 1'b0 || g_hist[b+11] !== 4'b0010) begin
            failures++;
            $display("FAIL to_regrant got=t%b g%b want=t0 g0010",
                     te_hist[b+11], g_hist[b+11]);
        end
`else
        te_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (te_hist[b+k] !== 1'b0 || g_hist[b+k] !== 4'b0001) te_seen = 1'b1;
        end
        checks++;
        if (te_seen) begin
            failures++;
            $display("FAIL no_to_hold got=release want=held 12 cycles");
        end
`endif
        hold[0] = 1'b0;
        run_until_empty(30);
        checks++;
        if (xfer_data.size() < lb + 3) begin
            failures++;
            $display("FAIL to_order got=%0d bytes want=3",
                     xfer_data.size() - lb);
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            if (xfer_data[lb+1] !== 8'hD0 || xfer_data[lb+2] !== 8'hC1) begin
                failures++;
                $display("FAIL to_order got=%h,%h want=D0,C1",
                         xfer_data[lb+1], xfer_data[lb+2]);
            end
`else
            if (xfer_data[lb+1] !== 8'hC1 || xfer_data[lb+2] !== 8'hD0) begin
                failures++;
                $display("FAIL to_order got=%h,%h want=C1,D0",
                         xfer_data[lb+1], xfer_data[lb+2]);
            end
`endif
        end
    endtask

    task automatic test_random();
        int len;
        logic [5:0] seq [N];
        for (int i = 0; i < N; i++) seq[i] = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q_data[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        push(i, {i[1:0], seq[i]}, j == len - 1);
                        seq[i] = seq[i] + 6'd1;
                    end
                end
                hold[i] = ($urandom_range(0, 9) == 0);
            end
            txrdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        txrdy = 1'b1;
        run_until_empty(500);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                failures++;
                $display("FAIL rand_stream req=%0d got=%0d left want=0",
                         i, exp_q[i].size());
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        txrdy     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_rr_basic();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single byte-wide UART transmit path of the SoC among N_REQ requesters, e.g. CPU console, boot loader and debug/trace source.
- Round-robin arbitration at packet granularity: once granted, a requester keeps the UART until it sends a byte flagged last.
- Sits between the requesters and the UART core's TX input, in the same clock domain as the system.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- DATA_W, 8, byte width of the TX path.
- TO_W, 16, width of the stall-timeout counter (used only with the optional feature).
- TIMEOUT, 1000, idle-stall cycles before a forced grant release (optional feature only, must fit in TO_W bits).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ*DATA_W  per-requester byte; requester i uses bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  byte is the final one of the packet.
- req_ready  out  N_REQ  per-requester accept.
- tx_valid  out  1  byte valid to the UART.
- tx_data  out  DATA_W  byte to the UART.
- tx_ready  in  1  UART accepts the byte.
- grant  out  N_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  high while a packet is owned (state LOCK).
- timeout_evt  out  1  one-cycle pulse on a forced release (tied 0 without the feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values:
  - state=IDLE, grant=0, busy=0, tx_valid=0, req_ready=0, timeout_evt=0.
  - Priority pointer last_idx=N_REQ-1, so requester 0 wins first.
- States: IDLE, LOCK.
- IDLE:
  - tx_valid=0, req_ready=0.
  - If any req_valid bit is set, pick the first set bit scanning last_idx+1, last_idx+2, ... modulo N_REQ.
  - Register the one-hot grant and index g, then go to LOCK.
  - Arbitration latency is exactly 1 cycle; no byte is accepted in the deciding cycle.
- LOCK, combinational pass-through (zero added latency):
  - tx_valid=req_valid[g], tx_data=req_data slice g.
  - req_ready[g]=tx_ready; every other req_ready bit is 0.
- Transfer: a transfer happens in a cycle where tx_valid and tx_ready are both high.
  - Transfer with req_last[g]=1: next state IDLE, last_idx<=g, grant<=0.
  - A new arbitration can then happen in the following IDLE cycle, so there is at least 1 idle cycle between packets.
- Stalls:
  - req_valid[g] low in LOCK: hold the grant indefinitely; other requesters wait.
  - tx_ready low: hold; tx_data stays equal to the owner's data.
- Multiple new requests arriving in IDLE: only the round-robin winner is granted; the losers keep their valid high.
- A requester dropping req_valid in the same cycle the grant is registered: the grant still holds (packet lock semantics).
- rst mid-packet:
  - Return to IDLE next edge and restore reset values, including last_idx.
  - The partial packet is abandoned; no flush.
- N_REQ=1: degenerates to a pass-through with 1-cycle entry latency per packet.
- Invariants the checker must enforce:
  - grant is one-hot or zero.
  - At most one req_ready bit is set.
  - busy==(grant!=0).
  - tx_valid is never high in IDLE.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter runs in LOCK while req_valid[g]=0 and clears on every transfer and on entry to LOCK.
  - Cycles with req_valid[g]=1 and tx_ready=0 do not count; that is legitimate UART backpressure.
  - When the counter reaches TIMEOUT: force IDLE, set last_idx<=g, clear grant, pulse timeout_evt for 1 cycle, clear the counter.
  - The counter resets to 0 on rst.
- Undefined: no counter logic; timeout_evt is constant 0; the grant is held until req_last.

Test Plan:
- Reset, then req_valid=2'b11 → requester 0 granted first. Its 3-byte packet 0x41,0x42,0x43 (last on the 3rd byte) appears on tx_data in order. Then requester 1 is granted after 1 idle cycle.
- Requester 1 sends a 2-byte packet, then both requesters keep requesting → grants alternate 0,1,0,1 over 4 packets. Verify each grant lasts exactly until its req_last transfer.
- Requester 0 owns the UART; tx_ready low for 20 cycles mid-packet while requester 1 is valid → grant stays 0, req_ready[1]=0 throughout, no byte lost or duplicated.
- Assert rst on the 2nd byte of a 4-byte packet → next cycle grant=0, busy=0, tx_valid=0. After reset, requester 0 wins again even if requester 1 was last.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=10: the owner drops req_valid for 10 cycles → timeout_evt pulses once, grant clears, the other waiting requester is granted 1 cycle later. A 9-cycle stall produces no timeout.
- Random valid/ready/last traffic on 4 requesters for 10k cycles → the scoreboard matches every per-requester byte stream, there is no interleaving within a packet, and the one-hot assertions hold.
